br_update_queue: RTL

//  Buffers resolved-branch outcomes from execute and issues one predictor update per cycle.

---
 rtl/bp_pkg.sv | 18 +
 rtl/sat_counter16.sv | 19 +
 rtl/br_update_queue.sv | 97 +++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: update record, table index mapping, saturation limit.
package bp_pkg;

    localparam int unsigned BP_PC_W  = 32;
    localparam int unsigned BP_IDX_W = 6;
    localparam logic [15:0] SAT16_MAX = 16'hFFFF;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
        logic               pred;
    } br_update_t;

    function automatic logic [BP_IDX_W-1:0] pc_to_idx(input logic [BP_PC_W-1:0] pc);
        return pc[BP_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit enable counter that sticks at SAT16_MAX; async active-low reset.
module sat_counter16
    import bp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (inc && (value != SAT16_MAX)) begin
            value <= value + 16'd1;
        end
    end

endmodule

// File: rtl/br_update_queue.sv
// FIFO of resolved branches feeding the predictor table's single update port.
// Optional dequeue/mispredict statistics when BUQ_STATS_EN is defined.
module br_update_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = BP_PC_W,
    parameter int unsigned IDX_W = BP_IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic                     enq_taken,
    input  logic                     enq_pred,
    output logic                     upd_en,
    input  logic                     upd_ready,
    output logic [IDX_W-1:0]         upd_idx,
    output logic                     upd_taken,
    output logic                     upd_mispred,
`ifdef BUQ_STATS_EN
    output logic [15:0]              stat_updates,
    output logic [15:0]              stat_mispred,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    br_update_t       mem [DEPTH];
    br_update_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enq_fire;
    logic             deq_fire;

    assign enq_ready = (count != FULL);
    assign upd_en    = (count != '0);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = upd_en && upd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            mem[wr_ptr] <= '{pc: enq_pc, taken: enq_taken, pred: enq_pred};
        end
    end

    // Storage is not reset, so the head is masked to zero while the queue is empty.
    assign head        = mem[rd_ptr];
    assign upd_idx     = upd_en ? pc_to_idx(head.pc) : '0;
    assign upd_taken   = upd_en && head.taken;
    assign upd_mispred = upd_en && (head.taken != head.pred);

`ifdef BUQ_STATS_EN
    logic stat_deq;
    assign stat_deq = deq_fire && !flush;

    sat_counter16 u_stat_updates (
        .clk   (clk),
        .reset (reset),
        .inc   (stat_deq),
        .value (stat_updates)
    );

    sat_counter16 u_stat_mispred (
        .clk   (clk),
        .reset (reset),
        .inc   (stat_deq && upd_mispred),
        .value (stat_mispred)
    );
`endif

endmodule
